// File: rtl/ysyx_22041207_axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package ysyx_22041207_axi_rd_arbiter_pkg;

  localparam int unsigned SIZE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Owner / last_grant encoding: 0 selects the fetch port, 1 the MEM-stage port.
  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  // Instruction fetches are always one 32-bit word.
  localparam logic [SIZE_W-1:0] IF_SIZE = SIZE_W'(4);

endpackage

// File: rtl/ysyx_22041207_axi_rd_arbiter_if.sv
// Bundle of the IF, MEM and downstream read channels seen by the arbiter.
interface ysyx_22041207_axi_rd_arbiter_if
  import ysyx_22041207_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);

  logic              if_r_valid_i;
  logic              if_r_ready_o;
  logic [ADDR_W-1:0] if_r_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_data_valid_o;
  logic              if_data_ready_i;

  logic              me_r_valid_i;
  logic              me_r_ready_o;
  logic [ADDR_W-1:0] me_r_addr_i;
  logic [SIZE_W-1:0] me_r_size_i;
  logic [DATA_W-1:0] me_data_o;
  logic              me_data_valid_o;
  logic              me_data_ready_i;

  logic              rx_r_valid_o;
  logic              rx_r_ready_i;
  logic [ADDR_W-1:0] rx_r_addr_o;
  logic [SIZE_W-1:0] rx_r_size_o;
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_data_valid_i;
  logic              rx_data_ready_o;

  // Arbiter side.
  modport slave (
    input  if_r_valid_i, if_r_addr_i, if_data_ready_i,
    input  me_r_valid_i, me_r_addr_i, me_r_size_i, me_data_ready_i,
    input  rx_r_ready_i, rx_data_i, rx_data_valid_i,
    output if_r_ready_o, if_data_o, if_data_valid_o,
    output me_r_ready_o, me_data_o, me_data_valid_o,
    output rx_r_valid_o, rx_r_addr_o, rx_r_size_o, rx_data_ready_o
  );

  // Requester / downstream-slave environment side.
  modport master (
    output if_r_valid_i, if_r_addr_i, if_data_ready_i,
    output me_r_valid_i, me_r_addr_i, me_r_size_i, me_data_ready_i,
    output rx_r_ready_i, rx_data_i, rx_data_valid_i,
    input  if_r_ready_o, if_data_o, if_data_valid_o,
    input  me_r_ready_o, me_data_o, me_data_valid_o,
    input  rx_r_valid_o, rx_r_addr_o, rx_r_size_o, rx_data_ready_o
  );

endinterface

// File: rtl/ysyx_22041207_rr_grant2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module ysyx_22041207_rr_grant2
  import ysyx_22041207_axi_rd_arbiter_pkg::*;
(
  input  logic req_if,
  input  logic req_me,
  input  logic last_grant,
  output logic gnt_valid_c,
  output logic gnt_owner_c
);

  always_comb begin
    gnt_valid_c = req_if | req_me;
    gnt_owner_c = OWNER_IF;
    if (req_if && req_me) begin
      gnt_owner_c = ~last_grant;
    end else if (req_me) begin
      gnt_owner_c = OWNER_MEM;
    end
  end

endmodule

// File: rtl/ysyx_22041207_axi_rd_arbiter.sv
// Arbitrates IF and MEM read requests onto one downstream read port, one transaction at a time.
module ysyx_22041207_axi_rd_arbiter
  import ysyx_22041207_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
)(
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22041207_axi_rd_arbiter_if.slave bus
);

  arb_state_e        state;
  logic              owner;
  logic              last_grant;
  logic              rx_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SIZE_W-1:0] size_q;

  logic              gnt_valid_c;
  logic              gnt_owner_c;
  logic              owner_ready_c;

  ysyx_22041207_rr_grant2 u_rr_grant2 (
    .req_if      (bus.if_r_valid_i),
    .req_me      (bus.me_r_valid_i),
    .last_grant  (last_grant),
    .gnt_valid_c (gnt_valid_c),
    .gnt_owner_c (gnt_owner_c)
  );

  assign owner_ready_c = (owner == OWNER_MEM) ? bus.me_data_ready_i : bus.if_data_ready_i;

  // Request-side registers: grant in IDLE, hold the downstream request through REQ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWNER_IF;
      last_grant <= OWNER_IF;
      rx_valid_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid_c) begin
            owner      <= gnt_owner_c;
            last_grant <= gnt_owner_c;
            rx_valid_q <= 1'b1;
            addr_q     <= (gnt_owner_c == OWNER_MEM) ? bus.me_r_addr_i : bus.if_r_addr_i;
            size_q     <= (gnt_owner_c == OWNER_MEM) ? bus.me_r_size_i : IF_SIZE;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.rx_r_ready_i) begin
            rx_valid_q <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE costs one cycle, so no grant can overlap the response.
          if (bus.rx_data_valid_i && owner_ready_c) begin
            state <= IDLE;
          end
        end
        default: begin
          rx_valid_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Grant readies and response routing are combinational on the registered state/owner.
  always_comb begin
    bus.if_r_ready_o    = 1'b0;
    bus.me_r_ready_o    = 1'b0;
    bus.if_data_o       = '0;
    bus.if_data_valid_o = 1'b0;
    bus.me_data_o       = '0;
    bus.me_data_valid_o = 1'b0;
    bus.rx_data_ready_o = 1'b0;

    if (rst_n && (state == IDLE) && gnt_valid_c) begin
      if (gnt_owner_c == OWNER_MEM) begin
        bus.me_r_ready_o = 1'b1;
      end else begin
        bus.if_r_ready_o = 1'b1;
      end
    end

    if (state == RESP) begin
      bus.rx_data_ready_o = owner_ready_c;
      if (owner == OWNER_MEM) begin
        bus.me_data_o       = bus.rx_data_i;
        bus.me_data_valid_o = bus.rx_data_valid_i;
      end else begin
        bus.if_data_o       = bus.rx_data_i;
        bus.if_data_valid_o = bus.rx_data_valid_i;
      end
    end
  end

  assign bus.rx_r_valid_o = rx_valid_q;
  assign bus.rx_r_addr_o  = addr_q;
  assign bus.rx_r_size_o  = size_q;

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_arbiter.sv
// Directed testbench for the IF/MEM read arbiter.
module tb_ysyx_22041207_axi_rd_arbiter;
  import ysyx_22041207_axi_rd_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22041207_axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ysyx_22041207_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stimulus only: called at the negedge where the DUT sits in REQ; completes the transaction.
  task automatic finish_txn();
    bus.rx_r_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_r_ready_i    = 1'b0;
    bus.rx_data_valid_i = 1'b1;
    bus.if_data_ready_i = 1'b1;
    bus.me_data_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_data_valid_i = 1'b0;
    bus.if_data_ready_i = 1'b0;
    bus.me_data_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_r_valid_i = 1'b1;
    bus.me_r_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    n_tests++; if (bus.if_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b want 0", bus.if_r_ready_o); end
    n_tests++; if (bus.me_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_me_ready: got %b want 0", bus.me_r_ready_o); end
    n_tests++; if (bus.rx_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_r_valid_o); end
    n_tests++; if (bus.rx_data_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_data_ready: got %b want 0", bus.rx_data_ready_o); end
    n_tests++; if ({bus.if_data_valid_o, bus.me_data_valid_o} !== 2'b00) begin n_fail++; $display("FAIL reset_data_valid: got %b want 00", {bus.if_data_valid_o, bus.me_data_valid_o}); end
    bus.if_r_valid_i = 1'b0;
    bus.me_r_valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_if();
    @(negedge clk);
    bus.if_r_valid_i = 1'b1;
    bus.if_r_addr_i  = 64'h8000_0000;
    #1;
    n_tests++; if (bus.if_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_if_grant: got %b want 1", bus.if_r_ready_o); end
    n_tests++; if (bus.me_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_if_me_ready: got %b want 0", bus.me_r_ready_o); end
    @(negedge clk);
    bus.if_r_valid_i = 1'b0;
    #1;
    n_tests++; if (bus.rx_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_if_rx_valid: got %b want 1", bus.rx_r_valid_o); end
    n_tests++; if (bus.rx_r_addr_o !== 64'h8000_0000) begin n_fail++; $display("FAIL single_if_addr: got %h want 80000000", bus.rx_r_addr_o); end
    n_tests++; if (bus.rx_r_size_o !== 8'd4) begin n_fail++; $display("FAIL single_if_size: got %0d want 4", bus.rx_r_size_o); end
    bus.rx_r_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_r_ready_i    = 1'b0;
    bus.rx_data_i       = 64'h1234;
    bus.rx_data_valid_i = 1'b1;
    bus.if_data_ready_i = 1'b1;
    #1;
    n_tests++; if (bus.if_data_o !== 64'h1234) begin n_fail++; $display("FAIL single_if_data: got %h want 1234", bus.if_data_o); end
    n_tests++; if (bus.if_data_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_if_data_valid: got %b want 1", bus.if_data_valid_o); end
    n_tests++; if (bus.me_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_if_me_valid: got %b want 0", bus.me_data_valid_o); end
    n_tests++; if (bus.rx_data_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_if_rx_data_ready: got %b want 1", bus.rx_data_ready_o); end
    n_tests++; if (bus.rx_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_if_rx_valid_drop: got %b want 0", bus.rx_r_valid_o); end
    @(negedge clk);
    bus.rx_data_valid_i = 1'b0;
    bus.if_data_ready_i = 1'b0;
    #1;
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL single_if_back_idle: got %0d want %0d", dut.state, IDLE); end
  endtask

  task automatic test_tie_and_gap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.if_r_valid_i = 1'b1;
    bus.if_r_addr_i  = 64'h8000_0004;
    bus.me_r_valid_i = 1'b1;
    bus.me_r_addr_i  = 64'h8000_1000;
    bus.me_r_size_i  = 8'd8;
    #1;
    n_tests++; if ({bus.me_r_ready_o, bus.if_r_ready_o} !== 2'b10) begin n_fail++; $display("FAIL tie_first_grant: got me/if=%b want 10", {bus.me_r_ready_o, bus.if_r_ready_o}); end
    @(negedge clk);
    bus.me_r_valid_i = 1'b0;
    #1;
    n_tests++; if (bus.rx_r_addr_o !== 64'h8000_1000) begin n_fail++; $display("FAIL tie_first_addr: got %h want 80001000", bus.rx_r_addr_o); end
    n_tests++; if (bus.rx_r_size_o !== 8'd8) begin n_fail++; $display("FAIL tie_first_size: got %0d want 8", bus.rx_r_size_o); end
    n_tests++; if (bus.if_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL tie_if_waits_req: got %b want 0", bus.if_r_ready_o); end
    bus.rx_r_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_r_ready_i    = 1'b0;
    bus.rx_data_i       = 64'hAA55;
    bus.rx_data_valid_i = 1'b1;
    bus.me_data_ready_i = 1'b1;
    #1;
    n_tests++; if (bus.me_data_o !== 64'hAA55) begin n_fail++; $display("FAIL tie_me_data: got %h want aa55", bus.me_data_o); end
    n_tests++; if (bus.if_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL tie_if_data_valid: got %b want 0", bus.if_data_valid_o); end
    n_tests++; if (bus.if_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL tie_no_grant_in_resp: got %b want 0", bus.if_r_ready_o); end
    @(negedge clk);
    bus.rx_data_valid_i = 1'b0;
    bus.me_data_ready_i = 1'b0;
    #1;
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL gap_idle_state: got %0d want %0d", dut.state, IDLE); end
    n_tests++; if (bus.if_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL gap_if_grant: got %b want 1", bus.if_r_ready_o); end
    @(negedge clk);
    bus.if_r_valid_i = 1'b0;
    #1;
    n_tests++; if (bus.rx_r_addr_o !== 64'h8000_0004) begin n_fail++; $display("FAIL tie_second_addr: got %h want 80000004", bus.rx_r_addr_o); end
    n_tests++; if (bus.rx_r_size_o !== 8'd4) begin n_fail++; $display("FAIL tie_second_size: got %0d want 4", bus.rx_r_size_o); end
    finish_txn();
  endtask

  task automatic test_alternate();
    logic        exp_mem;
    logic [63:0] exp_addr;
    bus.if_r_valid_i = 1'b1;
    bus.if_r_addr_i  = 64'h8000_0100;
    bus.me_r_valid_i = 1'b1;
    bus.me_r_addr_i  = 64'h8000_0200;
    bus.me_r_size_i  = 8'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_mem  = (i % 2 == 0);
      exp_addr = exp_mem ? 64'h8000_0200 : 64'h8000_0100;
      n_tests++; if ({bus.me_r_ready_o, bus.if_r_ready_o} !== {exp_mem, ~exp_mem}) begin n_fail++; $display("FAIL alternate_grant[%0d]: got me/if=%b want %b", i, {bus.me_r_ready_o, bus.if_r_ready_o}, {exp_mem, ~exp_mem}); end
      @(negedge clk);
      #1;
      n_tests++; if (bus.rx_r_addr_o !== exp_addr) begin n_fail++; $display("FAIL alternate_addr[%0d]: got %h want %h", i, bus.rx_r_addr_o, exp_addr); end
      finish_txn();
    end
    bus.if_r_valid_i = 1'b0;
    bus.me_r_valid_i = 1'b0;
  endtask

  task automatic test_slave_stall();
    bus.if_r_valid_i = 1'b1;
    bus.if_r_addr_i  = 64'h8000_0010;
    @(negedge clk);
    bus.if_r_valid_i = 1'b0;
    bus.me_r_valid_i = 1'b1;
    bus.me_r_addr_i  = 64'h8000_0300;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (bus.rx_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_rx_valid[%0d]: got %b want 1", i, bus.rx_r_valid_o); end
      n_tests++; if (bus.rx_r_addr_o !== 64'h8000_0010) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 80000010", i, bus.rx_r_addr_o); end
      n_tests++; if ({bus.me_r_ready_o, bus.if_r_ready_o} !== 2'b00) begin n_fail++; $display("FAIL stall_readies[%0d]: got %b want 00", i, {bus.me_r_ready_o, bus.if_r_ready_o}); end
      @(negedge clk);
    end
    bus.me_r_valid_i = 1'b0;
    finish_txn();
  endtask

  task automatic test_owner_stall();
    bus.me_r_valid_i = 1'b1;
    bus.me_r_addr_i  = 64'h8000_0400;
    bus.me_r_size_i  = 8'd8;
    @(negedge clk);
    bus.me_r_valid_i = 1'b0;
    bus.rx_r_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_r_ready_i    = 1'b0;
    bus.rx_data_i       = 64'hBEEF;
    bus.rx_data_valid_i = 1'b1;
    bus.me_data_ready_i = 1'b0;
    bus.if_data_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.rx_data_ready_o !== 1'b0) begin n_fail++; $display("FAIL owner_stall_rx_ready[%0d]: got %b want 0", i, bus.rx_data_ready_o); end
      n_tests++; if (dut.state !== RESP) begin n_fail++; $display("FAIL owner_stall_state[%0d]: got %0d want %0d", i, dut.state, RESP); end
      n_tests++; if (bus.if_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL owner_stall_if_valid[%0d]: got %b want 0", i, bus.if_data_valid_o); end
      n_tests++; if (bus.me_data_valid_o !== 1'b1) begin n_fail++; $display("FAIL owner_stall_me_valid[%0d]: got %b want 1", i, bus.me_data_valid_o); end
      @(negedge clk);
    end
    bus.me_data_ready_i = 1'b1;
    #1;
    n_tests++; if (bus.rx_data_ready_o !== 1'b1) begin n_fail++; $display("FAIL owner_release_rx_ready: got %b want 1", bus.rx_data_ready_o); end
    @(negedge clk);
    bus.rx_data_valid_i = 1'b0;
    bus.me_data_ready_i = 1'b0;
    bus.if_data_ready_i = 1'b0;
    #1;
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL owner_release_idle: got %0d want %0d", dut.state, IDLE); end
  endtask

  task automatic test_reset_mid();
    // MEM granted last, so only a reset makes the next tie go to MEM again.
    @(negedge clk);
    bus.me_r_valid_i = 1'b1;
    bus.me_r_addr_i  = 64'h8000_0500;
    @(negedge clk);
    bus.me_r_valid_i = 1'b0;
    #1;
    n_tests++; if (bus.rx_r_valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre_valid: got %b want 1", bus.rx_r_valid_o); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if (bus.rx_r_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_rx_valid: got %b want 0", bus.rx_r_valid_o); end
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_mid_state: got %0d want %0d", dut.state, IDLE); end
    rst_n = 1'b1;
    bus.if_r_valid_i = 1'b1;
    bus.me_r_valid_i = 1'b1;
    #1;
    n_tests++; if ({bus.me_r_ready_o, bus.if_r_ready_o} !== 2'b10) begin n_fail++; $display("FAIL reset_mid_tie: got me/if=%b want 10", {bus.me_r_ready_o, bus.if_r_ready_o}); end
    bus.if_r_valid_i = 1'b0;
    bus.me_r_valid_i = 1'b0;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.if_r_valid_i    = 1'b0;
    bus.if_r_addr_i     = '0;
    bus.if_data_ready_i = 1'b0;
    bus.me_r_valid_i    = 1'b0;
    bus.me_r_addr_i     = '0;
    bus.me_r_size_i     = '0;
    bus.me_data_ready_i = 1'b0;
    bus.rx_r_ready_i    = 1'b0;
    bus.rx_data_i       = '0;
    bus.rx_data_valid_i = 1'b0;

    test_reset();
    test_single_if();
    test_tie_and_gap();
    test_alternate();
    test_slave_stall();
    test_owner_stall();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
